// File: rtl/key_prov_pkg.sv
// Shared types and defaults for the key provisioning controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: FSM state enum, default unlock code / fail limit / idle timeout,
// and a saturating 2-bit increment used by the failed-attempt counter.
package key_prov_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_UNLOCKED = 3'd1,
    ST_WRITE    = 3'd2,
    ST_SEALED   = 3'd3,
    ST_ALARM    = 3'd4
  } kp_state_e;

  localparam logic [31:0] DEF_UNLOCK_CODE = 32'hA5C3_5A3C;
  localparam int          DEF_MAX_FAIL    = 3;
  localparam int          DEF_TIMEOUT     = 255;

  function automatic logic [1:0] sat_inc2(input logic [1:0] v);
    return (v == 2'd3) ? v : v + 2'd1;
  endfunction

endpackage

// File: rtl/key_provision_ctrl.sv
// Gates host key writes behind an unlock code, seals on request, alarms on repeated bad codes.
// Latency: all outputs registered, one edge after the causing input; kw_ready is comb from state.
// Backpressure: kw_ready high only in UNLOCKED; a key word is taken on kw_valid && kw_ready.
// Ports: clk/rst_n (async active-low); unlock_req/unlock_code; kw_valid/kw_data/kw_ready;
//   lock_req; rd_req/rd_priv; write_key/write_enable/read_enable/rd_denied to storage;
//   state_o, fail_cnt, alarm status.
// Build option: define KEY_SCRUB_EN to zeroize storage (one zero write) on entry to ALARM.
module key_provision_ctrl
  import key_prov_pkg::*;
#(
  parameter logic [31:0] UNLOCK_CODE = DEF_UNLOCK_CODE,
  parameter int          MAX_FAIL    = DEF_MAX_FAIL,
  parameter int          TIMEOUT     = DEF_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        unlock_req,
  input  logic [31:0] unlock_code,
  input  logic        kw_valid,
  input  logic [31:0] kw_data,
  output logic        kw_ready,
  input  logic        lock_req,
  input  logic        rd_req,
  input  logic        rd_priv,
  output logic [31:0] write_key,
  output logic        write_enable,
  output logic        read_enable,
  output logic        rd_denied,
  output logic [2:0]  state_o,
  output logic [1:0]  fail_cnt,
  output logic        alarm
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  kp_state_e   state_q, state_d;
  logic [31:0] write_key_q, write_key_d;
  logic        write_enable_q, write_enable_d;
  logic        read_enable_q, read_enable_d;
  logic        rd_denied_q, rd_denied_d;
  logic [1:0]  fail_cnt_q, fail_cnt_d;
  logic        alarm_q, alarm_d;
  logic [7:0]  timer_q, timer_d;

  logic [1:0]  fail_inc;
  logic [7:0]  timer_inc;
  logic        kw_hs;

  assign kw_ready  = (state_q == ST_UNLOCKED);
  assign kw_hs     = kw_valid && kw_ready;
  assign fail_inc  = sat_inc2(fail_cnt_q);
  assign timer_inc = timer_q + 8'd1;

  always_comb begin
    state_d     = state_q;
    write_key_d = write_key_q;
    fail_cnt_d  = fail_cnt_q;
    alarm_d     = alarm_q;
    // Timer only survives while idling in UNLOCKED; any other path clears it,
    // so every entry into UNLOCKED starts from zero.
    timer_d     = '0;

    case (state_q)
      ST_IDLE: begin
        if (lock_req) begin
          state_d = ST_SEALED;
        end else if (unlock_req) begin
          if (unlock_code == UNLOCK_CODE) begin
            state_d    = ST_UNLOCKED;
            fail_cnt_d = '0;
          end else begin
            fail_cnt_d = fail_inc;
            // Alarm on the same edge the count reaches the limit.
            if (int'(fail_inc) >= MAX_FAIL) begin
              state_d = ST_ALARM;
              alarm_d = 1'b1;
            end
          end
        end
      end
      ST_UNLOCKED: begin
        if (lock_req) begin
          state_d = ST_SEALED;
        end else if (kw_hs) begin
          write_key_d = kw_data;
          state_d     = ST_WRITE;
        end else if (timer_inc == TIMEOUT_CNT) begin
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_inc;
        end
      end
      // The write strobe is already out this cycle, so a lock only redirects the exit.
      ST_WRITE:  state_d = lock_req ? ST_SEALED : ST_IDLE;
      ST_SEALED,
      ST_ALARM: ;
      default:   state_d = ST_IDLE;
    endcase

    write_enable_d = (state_d == ST_WRITE);
`ifdef KEY_SCRUB_EN
    if ((state_d == ST_ALARM) && (state_q != ST_ALARM)) begin
      write_key_d    = '0;
      write_enable_d = 1'b1;
    end
`endif

    read_enable_d = rd_req && rd_priv && ((state_q == ST_IDLE) || (state_q == ST_SEALED));
    rd_denied_d   = rd_req && !read_enable_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      write_key_q    <= '0;
      write_enable_q <= 1'b0;
      read_enable_q  <= 1'b0;
      rd_denied_q    <= 1'b0;
      fail_cnt_q     <= '0;
      alarm_q        <= 1'b0;
      timer_q        <= '0;
    end else begin
      state_q        <= state_d;
      write_key_q    <= write_key_d;
      write_enable_q <= write_enable_d;
      read_enable_q  <= read_enable_d;
      rd_denied_q    <= rd_denied_d;
      fail_cnt_q     <= fail_cnt_d;
      alarm_q        <= alarm_d;
      timer_q        <= timer_d;
    end
  end

  assign write_key    = write_key_q;
  assign write_enable = write_enable_q;
  assign read_enable  = read_enable_q;
  assign rd_denied    = rd_denied_q;
  assign state_o      = state_q;
  assign fail_cnt     = fail_cnt_q;
  assign alarm        = alarm_q;

endmodule
